stm_update_ctrl: RTL
====================

Name: stm_update_ctrl

Overview:
- Scheduler that sequences the STM output pipeline. Issues the one-cycle UPDATE strobe to stm at a programmable period.
- Counts the DOUT_VALID beats returned for each update and holds off the next strobe until all DEPTH beats have arrived.
- Detects and flags overruns where the period expires before the pipeline has drained.
- Sits between the settings/timing logic and stm; drives stm's UPDATE input.

Parameters:
DEPTH, 249, number of DOUT_VALID beats (transducers) expected per update
PERIOD_W, 16, width of PERIOD and of the internal tick counter

Ports:
CLK  input  1  system clock
RST  input  1  reset; synchronous, active-high
ENABLE  input  1  level; 1 = schedule updates
PERIOD  input  PERIOD_W  clocks between UPDATE strobes; sampled at each ISSUE
DOUT_VALID  input  1  beat strobe from stm
CLR_OVERRUN  input  1  one-cycle pulse that clears OVERRUN
UPDATE  output  1  one-cycle strobe to stm
BUSY  output  1  1 while in ISSUE or COLLECT
OVERRUN  output  1  sticky overrun flag
UPDATE_CNT  output  16  issued-update count, wraps at 2^16
OVERRUN_CNT  output  16  overrun count (see Optional Feature)

Behaviour:
- Reset (RST=1 at posedge):
  - state=IDLE; UPDATE=0, BUSY=0, OVERRUN=0, UPDATE_CNT=0, OVERRUN_CNT=0.
  - Beat counter and tick counter are 0.
  - RST mid-COLLECT abandons the update. Beats still in flight after reset are ignored (state is IDLE).
- Effective period: P = max(PERIOD, 2). Sampled only on the ISSUE cycle; PERIOD changes take effect at the next ISSUE.
- IDLE:
  - UPDATE=0, BUSY=0.
  - ENABLE=1 -> ISSUE on the next cycle. Latency: ENABLE rise at cycle n gives UPDATE=1 at cycle n+1.
- ISSUE (exactly one cycle):
  - UPDATE=1; UPDATE_CNT += 1.
  - tick = P-1; beat = 0.
  - A DOUT_VALID on this cycle is ignored.
  - Next state: COLLECT.
- COLLECT:
  - Each DOUT_VALID increments beat; tick decrements every cycle (floors at 0).
  - beat reaches DEPTH with tick > 0: go to WAIT.
  - Final beat and tick = 0 on the same cycle: update counts as complete. Go to ISSUE if ENABLE=1, else IDLE. No overrun.
  - tick = 0 with beat < DEPTH: overrun.
    - OVERRUN <= 1; OVERRUN_CNT += 1 (saturating).
    - tick reloads to P-1 (the slot is skipped) and the state stays COLLECT.
    - No UPDATE is issued while beats are outstanding.
- WAIT:
  - BUSY=0; tick keeps decrementing.
  - tick = 0 and ENABLE=1: go to ISSUE. The ISSUE-to-ISSUE spacing is exactly P clocks.
  - ENABLE=0: go to IDLE immediately.
- ENABLE=0 during COLLECT: the current update drains to DEPTH beats, then the state goes to IDLE. No further ISSUE. Overrun detection stays active during the drain.
- DOUT_VALID outside COLLECT is ignored; beat never exceeds DEPTH.
- OVERRUN: set has priority over CLR_OVERRUN on the same cycle. CLR_OVERRUN does not affect OVERRUN_CNT.
- Widths:
  - beat is $clog2(DEPTH+1) bits.
  - tick is PERIOD_W bits.
  - UPDATE_CNT wraps; OVERRUN_CNT saturates at 16'hFFFF.
- All outputs are registered.

Optional Feature:
- Macro STM_UPDATE_CTRL_OVERRUN_CNT_EN.
- Defined: OVERRUN_CNT counts overrun events as described above; cleared only by RST.
- Undefined: OVERRUN_CNT is tied to 0 and the counter logic is omitted. OVERRUN and all other behaviour are unchanged.

Test Plan:
1. DEPTH=249, PERIOD=400, ENABLE rises at cycle 10; drive 249 beats, one per cycle, starting 3 cycles after each UPDATE -> UPDATE at cycles 11, 411, 811; BUSY low from the last beat until the next ISSUE; OVERRUN=0; UPDATE_CNT=3 after cycle 811.
2. PERIOD=200, drive 249 beats -> OVERRUN=1 at ISSUE+199, no UPDATE in that slot; next UPDATE the cycle after beat 249 arrives if its slot boundary has passed, otherwise at that boundary; OVERRUN_CNT=1 (macro on) or 0 (macro off).
3. Beat 249 arrives on the same cycle tick reaches 0 -> no overrun; UPDATE on the next cycle.
4. ENABLE falls mid-COLLECT after beat 100 -> remaining 149 beats are accepted, then IDLE; no further UPDATE; BUSY=0.
5. RST pulse mid-COLLECT with beats continuing -> all outputs 0 on the next cycle; beats ignored; with ENABLE still 1, UPDATE again the cycle after RST deasserts.
6. OVERRUN set, then CLR_OVERRUN on the same cycle as a new overrun -> OVERRUN stays 1; CLR_OVERRUN alone on a later cycle -> OVERRUN=0.

Source files
------------

// File: rtl/stm_update_ctrl.sv
// STM update scheduler: issues UPDATE every max(PERIOD,2) clocks, collects DEPTH beats, flags overruns.
// Optional saturating overrun counter enabled by defining STM_UPDATE_CTRL_OVERRUN_CNT_EN.
module stm_update_ctrl #(
   parameter int DEPTH    = 249,
   parameter int PERIOD_W = 16
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                ENABLE,
   input  logic [PERIOD_W-1:0] PERIOD,
   input  logic                DOUT_VALID,
   input  logic                CLR_OVERRUN,
   output logic                UPDATE,
   output logic                BUSY,
   output logic                OVERRUN,
   output logic [15:0]         UPDATE_CNT,
   output logic [15:0]         OVERRUN_CNT
);
   localparam int                BEAT_W    = $clog2(DEPTH + 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DEPTH - 1);
   localparam logic [BEAT_W-1:0] FULL_BEAT = BEAT_W'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COLLECT, S_WAIT} state_t;

   state_t              state, state_nxt;
   logic [BEAT_W-1:0]   beat, beat_nxt;
   logic [PERIOD_W-1:0] tick, tick_nxt;
   logic [PERIOD_W-1:0] per, per_nxt;
   logic [PERIOD_W-1:0] p_eff, tick_dec;
   logic                last_beat, ovr_evt;

   assign p_eff     = (PERIOD < PERIOD_W'(2)) ? PERIOD_W'(2) : PERIOD;
   assign tick_dec  = (tick == '0) ? '0 : tick - PERIOD_W'(1);
   assign last_beat = DOUT_VALID && (beat == LAST_BEAT);

   always_comb begin
      state_nxt = state;
      beat_nxt  = beat;
      tick_nxt  = tick;
      per_nxt   = per;
      ovr_evt   = 1'b0;
      case (state)
         S_IDLE: begin
            if (ENABLE) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            // tick is loaded one below P-1 because it is first seen the cycle after ISSUE
            per_nxt   = p_eff;
            tick_nxt  = p_eff - PERIOD_W'(2);
            beat_nxt  = '0;
            state_nxt = S_COLLECT;
         end
         S_COLLECT: begin
            tick_nxt = tick_dec;
            if (DOUT_VALID && (beat != FULL_BEAT)) beat_nxt = beat + BEAT_W'(1);
            if (last_beat) begin
               if (!ENABLE)          state_nxt = S_IDLE;
               else if (tick == '0)  state_nxt = S_ISSUE;
               else                  state_nxt = S_WAIT;
            end else if (tick == '0) begin
               // slot expired with beats outstanding: skip it and keep collecting
               ovr_evt  = 1'b1;
               tick_nxt = per - PERIOD_W'(1);
            end
         end
         S_WAIT: begin
            tick_nxt = tick_dec;
            if (!ENABLE)          state_nxt = S_IDLE;
            else if (tick == '0)  state_nxt = S_ISSUE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         beat       <= '0;
         tick       <= '0;
         per        <= '0;
         UPDATE     <= 1'b0;
         BUSY       <= 1'b0;
         OVERRUN    <= 1'b0;
         UPDATE_CNT <= '0;
      end else begin
         state  <= state_nxt;
         beat   <= beat_nxt;
         tick   <= tick_nxt;
         per    <= per_nxt;
         UPDATE <= (state_nxt == S_ISSUE);
         BUSY   <= (state_nxt == S_ISSUE) || (state_nxt == S_COLLECT);
         if (state_nxt == S_ISSUE) UPDATE_CNT <= UPDATE_CNT + 16'd1;
         if (ovr_evt)          OVERRUN <= 1'b1;
         else if (CLR_OVERRUN) OVERRUN <= 1'b0;
      end
   end

`ifdef STM_UPDATE_CTRL_OVERRUN_CNT_EN
   always_ff @(posedge CLK) begin
      if (RST)
         OVERRUN_CNT <= '0;
      else if (ovr_evt && (OVERRUN_CNT != 16'hFFFF))
         OVERRUN_CNT <= OVERRUN_CNT + 16'd1;
   end
`else
   assign OVERRUN_CNT = '0;
`endif

endmodule
